sgbm_disp_select: RTL and testbench

Winner-take-all disparity selection stage directly downstream of the right-to-left aggregator. Each valid cycle it sums the two per-disparity aggregated cost vectors for one pixel (current-direction costs and costs read back from the line RAM), finds the minimum-cost disparity, applies a uniqueness test and a left-border mask, and emits one disparity per pixel in a fixed 3-cycle pipeline. It also counts columns and flags the last pixel of each line.

---
 rtl/sgbm_disp_select.sv | 156 +++++++++++++++
 tb/tb_sgbm_disp_select.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sgbm_disp_select.sv
// Winner-take-all disparity selection: sum two aggregated cost vectors, pick the
// lowest-cost disparity, apply uniqueness and left-border masks, 3-cycle pipeline.

module sgbm_uniq_lane #(
  parameter int LANE      = 0,
  parameter int COST_BITS = 16,
  parameter int IDX_BITS  = 6,
  parameter int DISP_BITS = 7
) (
  input  logic [COST_BITS:0]   cost,
  input  logic [COST_BITS:0]   smin,
  input  logic [IDX_BITS-1:0]  kb,
  input  logic [DISP_BITS-1:0] rng,
  input  logic [6:0]           ratio,
  output logic                 ok
);
  localparam int PW = COST_BITS + 8;
  localparam logic [IDX_BITS:0] ONE = 1;

  logic [IDX_BITS:0] lane, kbw;
  logic              near, in_rng;
  logic [6:0]        scale;
  logic [PW-1:0]     lhs, rhs;

  assign lane   = (IDX_BITS+1)'(LANE);
  assign kbw    = {1'b0, kb};
  // Immediate neighbours of the winner are exempt from the uniqueness test.
  assign near   = (lane == kbw) || (lane == kbw + ONE) || (lane + ONE == kbw);
  assign in_rng = DISP_BITS'(LANE) < rng;
  assign scale  = 7'd100 - ratio;
  assign lhs    = PW'(cost) * PW'(scale);
  assign rhs    = PW'(smin) * PW'(100);
  assign ok     = near || !in_rng || (lhs > rhs);
endmodule

module sgbm_disp_select #(
  parameter int DISPD      = 64,
  parameter int COST_BITS  = 16,
  parameter int WIDTH_BITS = 11,
  parameter int DISP_BITS  = $clog2(DISPD) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DISPD*COST_BITS-1:0] i_cost_a,
  input  logic [DISPD*COST_BITS-1:0] i_cost_b,
  input  logic                       i_valid,
  input  logic                       i_line_start,
  input  logic [DISP_BITS-1:0]       i_min_disp,
  input  logic [DISP_BITS-1:0]       i_max_disp,
  input  logic [6:0]                 i_uniq_ratio,
  input  logic [WIDTH_BITS-1:0]      i_border_cols,
  input  logic [WIDTH_BITS-1:0]      i_width,
  output logic [DISP_BITS-1:0]       o_disp,
  output logic [COST_BITS:0]         o_min_cost,
  output logic                       o_valid,
  output logic                       o_line_done
);
  localparam int SW     = COST_BITS + 1;
  localparam int IW     = $clog2(DISPD);
  localparam int STAGES = 3;

  logic [STAGES:1]              vld_pipe;
  logic [DISP_BITS-1:0]         rng;
  logic [WIDTH_BITS-1:0]        last_col, col_cnt, col_x, col_nxt, x1, x2;
  logic [DISPD-1:0][SW-1:0]     sum_d, s1, s2;
  logic [SW-1:0]                tc [2*DISPD-1];
  logic [IW-1:0]                ti [2*DISPD-1];
  logic [SW-1:0]                min_d, min2;
  logic [IW-1:0]                kb_d, kb2;
  logic [DISPD-1:0]             uniq_ok;

  assign rng      = i_max_disp - i_min_disp;
  assign last_col = i_width - WIDTH_BITS'(1);
  assign o_valid  = vld_pipe[STAGES];

  // Out-of-range entries saturate so they can never win the min search.
  for (genvar k = 0; k < DISPD; k++) begin : g_sum
    logic [COST_BITS-1:0] ca, cb;
    assign ca       = i_cost_a[(DISPD-1-k)*COST_BITS +: COST_BITS];
    assign cb       = i_cost_b[(DISPD-1-k)*COST_BITS +: COST_BITS];
    assign sum_d[k] = (DISP_BITS'(k) < rng) ? SW'(ca) + SW'(cb) : '1;
  end

  always_comb begin
    col_x   = i_line_start ? '0 : col_cnt;
    col_nxt = col_x;
    if (i_valid) col_nxt = (col_x == last_col) ? '0 : col_x + WIDTH_BITS'(1);
  end

  // Heap-ordered min tree; on ties the left (lower index) child wins.
  always_comb begin
    for (int k = 0; k < DISPD; k++) begin
      tc[DISPD-1+k] = s1[k];
      ti[DISPD-1+k] = IW'(k);
    end
    for (int n = DISPD-2; n >= 0; n--) begin
      if (tc[2*n+2] < tc[2*n+1]) begin
        tc[n] = tc[2*n+2];
        ti[n] = ti[2*n+2];
      end else begin
        tc[n] = tc[2*n+1];
        ti[n] = ti[2*n+1];
      end
    end
    min_d = tc[0];
    kb_d  = ti[0];
  end

  for (genvar k = 0; k < DISPD; k++) begin : g_lane
    sgbm_uniq_lane #(.LANE(k), .COST_BITS(COST_BITS), .IDX_BITS(IW), .DISP_BITS(DISP_BITS)) u_lane (
      .cost (s2[k]),
      .smin (min2),
      .kb   (kb2),
      .rng  (rng),
      .ratio(i_uniq_ratio),
      .ok   (uniq_ok[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt  <= '0;
      vld_pipe <= '0;
    end else begin
      col_cnt  <= col_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (i_valid) begin
      s1 <= sum_d;
      x1 <= col_x;
    end
    if (vld_pipe[1]) begin
      s2   <= s1;
      x2   <= x1;
      kb2  <= kb_d;
      min2 <= min_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_disp      <= '0;
      o_min_cost  <= '0;
      o_line_done <= 1'b0;
    end else begin
      o_line_done <= vld_pipe[2] && (x2 == last_col);
      if (vld_pipe[2]) begin
        o_disp     <= (&uniq_ok && x2 >= i_border_cols) ? i_min_disp + DISP_BITS'(kb2) : '1;
        o_min_cost <= min2;
      end
    end
  end
endmodule

// File: tb/tb_sgbm_disp_select.sv
// Bench for sgbm_disp_select: directed literal cases plus randomized traffic
// checked every cycle against a per-pixel behavioural model.

module tb_sgbm_disp_select;
  localparam int DISPD = 64, CB = 16, WB = 11, DB = 7;

  logic                  clk = 1'b0, rst;
  logic [DISPD*CB-1:0]   i_cost_a, i_cost_b;
  logic                  i_valid, i_line_start;
  logic [DB-1:0]         i_min_disp, i_max_disp;
  logic [6:0]            i_uniq_ratio;
  logic [WB-1:0]         i_border_cols, i_width;
  logic [DB-1:0]         o_disp;
  logic [CB:0]           o_min_cost;
  logic                  o_valid, o_line_done;

  sgbm_disp_select #(.DISPD(DISPD), .COST_BITS(CB), .WIDTH_BITS(WB)) dut (
    .clk(clk), .rst(rst), .i_cost_a(i_cost_a), .i_cost_b(i_cost_b),
    .i_valid(i_valid), .i_line_start(i_line_start), .i_min_disp(i_min_disp),
    .i_max_disp(i_max_disp), .i_uniq_ratio(i_uniq_ratio), .i_border_cols(i_border_cols),
    .i_width(i_width), .o_disp(o_disp), .o_min_cost(o_min_cost), .o_valid(o_valid),
    .o_line_done(o_line_done)
  );

  always #5 clk = ~clk;

  typedef struct {int unsigned due; logic [DB-1:0] disp; logic [CB:0] cost; logic done;} exp_t;
  exp_t        q[$];
  int unsigned cyc = 0;
  int          mcol = 0;
  int          total = 0, bad = 0;
  int          sval[DISPD];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, want, $time);
    end
  endtask

  // Spec-level pixel model: plain sums, lowest-index min, uniqueness ratio, border.
  function automatic void model_pix(input logic [DISPD*CB-1:0] a, b, input int mind, maxd,
                                    ratio, border, x, output logic [DB-1:0] disp,
                                    output logic [CB:0] cost);
    int     r, kb;
    longint s[DISPD];
    longint smin;
    bit     uniq;
    r = maxd - mind; kb = 0; smin = 64'h7fff_ffff; uniq = 1;
    for (int k = 0; k < r; k++) begin
      s[k] = longint'(a[(DISPD-1-k)*CB +: CB]) + longint'(b[(DISPD-1-k)*CB +: CB]);
      if (s[k] < smin) begin smin = s[k]; kb = k; end
    end
    for (int k = 0; k < r; k++)
      if ((k > kb + 1 || k < kb - 1) && !(s[k] * (100 - ratio) > smin * 100)) uniq = 0;
    disp = (uniq && x >= border) ? DB'(mind + kb) : '1;
    cost = (CB+1)'(smin);
  endfunction

  initial forever begin
    exp_t e;
    int   x;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      mcol = 0;
    end else begin
      if (i_line_start) mcol = 0;
      if (i_valid) begin
        x    = mcol;
        mcol = (mcol == int'(i_width) - 1) ? 0 : mcol + 1;
        model_pix(i_cost_a, i_cost_b, int'(i_min_disp), int'(i_max_disp), int'(i_uniq_ratio),
                  int'(i_border_cols), x, e.disp, e.cost);
        e.due  = cyc + 2;
        e.done = (x == int'(i_width) - 1);
        q.push_back(e);
      end
    end
  end

  initial forever begin
    exp_t e;
    bit   ev;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("o_valid", 32'(o_valid), 32'(ev));
    if (ev) begin
      e = q.pop_front();
      chk("o_disp", 32'(o_disp), 32'(e.disp));
      chk("o_min_cost", 32'(o_min_cost), 32'(e.cost));
      chk("o_line_done", 32'(o_line_done), 32'(e.done));
    end else begin
      chk("o_line_done_idle", 32'(o_line_done), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0; i_line_start = 1'b0;
    repeat (n) step();
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < DISPD; k++) sval[k] = v;
  endtask

  // Split each target sum randomly between the two directions.
  task automatic load_s();
    int bk;
    for (int k = 0; k < DISPD; k++) begin
      bk = int'($urandom_range(sval[k], 0));
      i_cost_b[(DISPD-1-k)*CB +: CB] = CB'(bk);
      i_cost_a[(DISPD-1-k)*CB +: CB] = CB'(sval[k] - bk);
    end
  endtask

  task automatic pix1(input string nm, input int ed, input int ec);
    load_s();
    i_valid = 1'b1; step();
    i_valid = 1'b0; step(); step();
    chk({nm, "_v"}, 32'(o_valid), 32'd1);
    chk({nm, "_d"}, 32'(o_disp), 32'(ed));
    chk({nm, "_c"}, 32'(o_min_cost), 32'(ec));
    idle(2);
  endtask

  initial begin
    int ld_cnt, inv_cnt, mind, r, mode, kk;
    rst = 1'b1; i_valid = 1'b0; i_line_start = 1'b0;
    i_cost_a = '0; i_cost_b = '0;
    i_min_disp = 7'd0; i_max_disp = 7'd64; i_uniq_ratio = 7'd10;
    i_border_cols = '0; i_width = 11'd2047;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_disp", 32'(o_disp), 32'd0);
    chk("rst_cost", 32'(o_min_cost), 32'd0);
    chk("rst_done", 32'(o_line_done), 32'd0);
    rst = 1'b0;
    step();

    fill(1000); sval[20] = 100;                         pix1("basic", 20, 100);
    fill(500);  sval[5] = 50; sval[6] = 50;             pix1("tie_adj", 5, 50);
    fill(500);  sval[5] = 50; sval[9] = 50;             pix1("tie_far", 127, 50);
    fill(1000); sval[10] = 100; sval[11] = 105; sval[30] = 108;
    pix1("uniq_fail", 127, 100);
    sval[30] = 112;                                     pix1("uniq_pass", 10, 100);
    i_min_disp = 7'd4; i_max_disp = 7'd20;
    fill(1000); sval[40] = 0; sval[3] = 200;            pix1("range", 7, 200);
    i_min_disp = 7'd9; i_max_disp = 7'd10;
    fill(300);  sval[0] = 777;                          pix1("r1", 9, 777);

    // One 8-pixel line with 3 masked columns, then a second line via wrap.
    i_min_disp = 7'd0; i_max_disp = 7'd64; i_border_cols = 11'd3; i_width = 11'd8;
    ld_cnt = 0; inv_cnt = 0;
    for (int p = 0; p < 19; p++) begin
      if (p < 16) begin
        fill(1000); sval[(p * 5) % 64] = 100; load_s();
        i_valid = 1'b1; i_line_start = (p == 0);
      end else begin
        i_valid = 1'b0; i_line_start = 1'b0;
      end
      step();
      if (o_line_done) ld_cnt++;
      if (o_valid && o_disp == 7'h7f) inv_cnt++;
    end
    chk("line_done_cnt", 32'(ld_cnt), 32'd2);
    chk("border_inval_cnt", 32'(inv_cnt), 32'd6);
    idle(2);

    // Reset with two pixels in flight.
    i_border_cols = 11'd1;
    fill(1000); sval[7] = 100; load_s();
    i_valid = 1'b1; i_line_start = 1'b1; step();
    i_line_start = 1'b0; step();
    i_valid = 1'b0; rst = 1'b1; step();
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_disp", 32'(o_disp), 32'd0);
    chk("midrst_cost", 32'(o_min_cost), 32'd0);
    rst = 1'b0;
    idle(3);
    pix1("post_rst_col0", 127, 100);
    pix1("post_rst_col1", 7, 100);

    for (int blk = 0; blk < 6; blk++) begin
      mind = int'($urandom_range(20, 0));
      r    = int'($urandom_range(64, 1));
      i_min_disp = DB'(mind); i_max_disp = DB'(mind + r);
      i_uniq_ratio  = 7'($urandom_range(99, 0));
      i_border_cols = WB'($urandom_range(4, 0));
      i_width       = WB'($urandom_range(12, 3));
      for (int c = 0; c < 60; c++) begin
        mode = int'($urandom_range(2, 0));
        if (mode == 0) begin
          for (int k = 0; k < DISPD; k++) begin
            i_cost_a[(DISPD-1-k)*CB +: CB] = CB'($urandom);
            i_cost_b[(DISPD-1-k)*CB +: CB] = CB'($urandom);
          end
        end else if (mode == 1) begin
          fill(int'($urandom_range(3000, 1000)));
          kk = int'($urandom_range(63, 0));
          sval[kk] = int'($urandom_range(1500, 300));
          if ($urandom_range(1, 0) == 1)
            sval[$urandom_range(63, 0)] = sval[kk] + int'($urandom_range(100, 0));
          load_s();
        end else begin
          fill(int'($urandom_range(50, 0)));
          load_s();
        end
        i_valid      = ($urandom_range(9, 0) < 7);
        i_line_start = (c == 0) || ($urandom_range(19, 0) == 0);
        step();
      end
      idle(4);
    end

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
